rate_adapt_fifo: RTL



---
 rtl/rate_adapt_fifo_pkg.sv | 18 +
 rtl/rate_adapt_fifo_tick_gen.sv | 32 +++
 rtl/rate_adapt_fifo.sv | 109 ++++++++++
 3 files changed

// File: rtl/rate_adapt_fifo_pkg.sv
// Shared width helpers for the rate-adaptation FIFO and its read-tick generator.
// Defined as constant functions so each instance sizes itself from its own parameters.
package rate_adapt_fifo_pkg;

  function automatic int level_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // A divide-by-1 still needs a 1-bit counter so the vector is never zero width.
  function automatic int div_cnt_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

endpackage

// File: rtl/rate_adapt_fifo_tick_gen.sv
// Free-running divider that paces the consumer side.
// It produces one read opportunity every RD_DIV cycles, or every cycle when RD_DIV is 1.
module rate_tick_gen
  import rate_adapt_fifo_pkg::*;
#(
  parameter int RD_DIV = 4
) (
  input  logic i_clock,
  input  logic i_reset,
  output logic o_rd_tick
);

  localparam int CW = div_cnt_width(RD_DIV);
  localparam logic [CW-1:0] LAST = CW'(RD_DIV - 1);

  logic [CW-1:0] r_count;
  logic          w_last;

  assign w_last    = (r_count == LAST);
  assign o_rd_tick = w_last;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_count <= '0;
    end else if (w_last) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/rate_adapt_fifo.sv
// Single-clock buffer that decouples a burst producer from a consumer paced by a read tick.
// It reports occupancy and threshold flags, and latches sticky overflow and underflow errors.
module rate_adapt_fifo
  import rate_adapt_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1,
  parameter int RD_DIV     = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          data_1_en,
  input  logic [DATA_WIDTH-1:0]         data_1,
  input  logic                          data_2_ready,
  output logic [DATA_WIDTH-1:0]         data_2,
  output logic                          data_2_valid,
  output logic                          buffer_empty,
  output logic                          buffer_full,
  output logic                          almost_full,
  output logic                          almost_empty,
  output logic [level_width(DEPTH)-1:0] level,
  output logic                          overflow,
  output logic                          underflow
);

  localparam int LW = level_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
  logic [LW-1:0]         r_level, w_level_nxt;
  logic [DATA_WIDTH-1:0] r_data_2;
  logic                  r_valid, r_empty, r_full, r_af, r_ae, r_ovf, r_udf;
  logic                  w_rd_tick, w_push, w_pop;

  rate_tick_gen #(.RD_DIV(RD_DIV)) u_tick (
    .i_clock   (clock),
    .i_reset   (reset),
    .o_rd_tick (w_rd_tick)
  );

  // Full is judged on the registered level, so a same-cycle pop never makes room for a push.
  assign w_push = data_1_en && !r_full;
  assign w_pop  = w_rd_tick && data_2_ready && !r_empty;

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + LW'(1);
    end else if (w_pop && !w_push) begin
      w_level_nxt = r_level - LW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= data_1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_data_2 <= '0;
      r_valid  <= 1'b0;
      r_empty  <= 1'b1;
      r_full   <= 1'b0;
      r_af     <= 1'b0;
      r_ae     <= 1'b1;
      r_ovf    <= 1'b0;
      r_udf    <= 1'b0;
    end else begin
      r_valid <= w_pop;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_data_2 <= r_mem[r_rd_ptr];
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      r_level <= w_level_nxt;
      r_empty <= (w_level_nxt == '0);
      r_full  <= (w_level_nxt == LW'(DEPTH));
      r_af    <= (w_level_nxt >= LW'(AF_LEVEL));
      r_ae    <= (w_level_nxt <= LW'(AE_LEVEL));
      if (data_1_en && r_full) begin
        r_ovf <= 1'b1;
      end
      if (w_rd_tick && data_2_ready && r_empty) begin
        r_udf <= 1'b1;
      end
    end
  end

  assign data_2       = r_data_2;
  assign data_2_valid = r_valid;
  assign buffer_empty = r_empty;
  assign buffer_full  = r_full;
  assign almost_full  = r_af;
  assign almost_empty = r_ae;
  assign level        = r_level;
  assign overflow     = r_ovf;
  assign underflow    = r_udf;

endmodule
